store_buffer: RTL and testbench

- Circular store buffer between execute/memory stage and data memory.
- Stores are allocated speculatively at execute and return an index that travels to the ROB.
- Entries are marked committed when the ROB commits the store, and are dropped by the ROB's per-entry discard vector on flush.
- Committed entries drain in order to the data memory through a req/ready + resp handshake.

---
 rtl/store_buffer.sv | 188 ++++++++++++++++++
 tb/tb_store_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store buffer with in-order committed drain to data memory
// Optional feature macro: STORE_FORWARDING_EN (youngest word-to-word store-to-load forwarding)
module store_buffer #(
  parameter int STORE_BUFFER_SIZE = 4,
  parameter int IDX_W             = $clog2(STORE_BUFFER_SIZE)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         alloc_valid_i,
  input  logic [31:0]                  alloc_addr_i,
  input  logic [31:0]                  alloc_data_i,
  input  logic [1:0]                   alloc_size_i,
  output logic [IDX_W-1:0]             alloc_idx_o,
  output logic                         full_o,
  output logic                         empty_o,
  input  logic                         commit_valid_i,
  input  logic [IDX_W-1:0]             commit_idx_i,
  input  logic [STORE_BUFFER_SIZE-1:0] discard_i,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [31:0]                  mem_req_addr_o,
  output logic [31:0]                  mem_req_data_o,
  output logic [3:0]                   mem_req_wstrb_o,
  input  logic                         mem_resp_valid_i,
  input  logic [31:0]                  ld_addr_i,
  input  logic [1:0]                   ld_size_i,
  output logic                         ld_conflict_o,
  output logic                         fwd_hit_o,
  output logic [31:0]                  fwd_data_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(STORE_BUFFER_SIZE);

  logic [STORE_BUFFER_SIZE-1:0] valid_q, valid_d, committed_q, committed_d;
  logic [31:0] addr_q [STORE_BUFFER_SIZE];
  logic [31:0] data_q [STORE_BUFFER_SIZE];
  logic [1:0]  size_q [STORE_BUFFER_SIZE];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d, survivors;
  logic [1:0]       state_q, state_d;
  logic             any_discard, alloc_fire, drain_done;

  assign full_o      = (count_q == FULL_CNT);
  assign empty_o     = (count_q == '0);
  assign alloc_idx_o = tail_q;

  always_comb begin
    committed_d = committed_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    survivors   = '0;
    any_discard = |discard_i;
    alloc_fire  = alloc_valid_i && !full_o && !any_discard;
    drain_done  = (state_q == ST_WAIT) && mem_resp_valid_i;

    // Commit lands before the squash so a same-cycle commit protects its entry.
    if (commit_valid_i && valid_q[commit_idx_i]) committed_d[commit_idx_i] = 1'b1;
    valid_d     = valid_q & ~(discard_i & ~committed_d);
    committed_d = committed_d & valid_d;

    if (alloc_fire) begin
      valid_d[tail_q]     = 1'b1;
      committed_d[tail_q] = 1'b0;
      tail_d              = tail_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: if (valid_q[head_q] && committed_q[head_q]) state_d = ST_REQ;
      ST_REQ:  if (mem_req_ready_i) state_d = ST_WAIT;
      ST_WAIT: if (mem_resp_valid_i) begin
        valid_d[head_q]     = 1'b0;
        committed_d[head_q] = 1'b0;
        head_d              = head_q + 1'b1;
        state_d             = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Survivors of a squash are the committed run starting at head.
    if (any_discard) begin
      for (int i = 0; i < STORE_BUFFER_SIZE; i++) survivors = survivors + (IDX_W+1)'(valid_d[i]);
      count_d = survivors;
      tail_d  = head_d + survivors[IDX_W-1:0];
    end else begin
      count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(drain_done);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      committed_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
    end else begin
      valid_q     <= valid_d;
      committed_q <= committed_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      addr_q[tail_q] <= alloc_addr_i;
      data_q[tail_q] <= alloc_data_i;
      size_q[tail_q] <= alloc_size_i;
    end
  end

  logic [1:0] head_off;
  logic [4:0] head_shift;
  assign head_off   = addr_q[head_q][1:0];
  assign head_shift = {head_off, 3'b000};

  always_comb begin
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_data_o  = '0;
    mem_req_wstrb_o = '0;
    if (state_q == ST_REQ) begin
      mem_req_valid_o = 1'b1;
      mem_req_addr_o  = {addr_q[head_q][31:2], 2'b00};
      case (size_q[head_q])
        2'b00: begin
          mem_req_wstrb_o = 4'b0001 << head_off;
          mem_req_data_o  = {24'b0, data_q[head_q][7:0]} << head_shift;
        end
        2'b01: begin
          mem_req_wstrb_o = 4'b0011 << head_off;
          mem_req_data_o  = {16'b0, data_q[head_q][15:0]} << head_shift;
        end
        default: begin
          mem_req_wstrb_o = 4'hF;
          mem_req_data_o  = data_q[head_q];
        end
      endcase
    end
  end

  logic unused_ld;
  assign unused_ld = ^{ld_size_i, ld_addr_i[1:0]};

`ifdef STORE_FORWARDING_EN
  logic [IDX_W-1:0] lk_idx;
  logic             lk_found;
  always_comb begin
    ld_conflict_o = 1'b0;
    fwd_hit_o     = 1'b0;
    fwd_data_o    = '0;
    lk_found      = 1'b0;
    lk_idx        = '0;
    // Walk from the youngest entry toward head; the first match decides.
    for (int k = 0; k < STORE_BUFFER_SIZE; k++) begin
      lk_idx = tail_q - IDX_W'(k + 1);
      if (!lk_found && ((IDX_W+1)'(k) < count_q) && valid_q[lk_idx] &&
          (addr_q[lk_idx][31:2] == ld_addr_i[31:2])) begin
        lk_found = 1'b1;
        if (size_q[lk_idx][1] && ld_size_i[1]) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = data_q[lk_idx];
        end else begin
          ld_conflict_o = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    ld_conflict_o = 1'b0;
    for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
      if (valid_q[i] && (addr_q[i][31:2] == ld_addr_i[31:2])) ld_conflict_o = 1'b1;
    end
  end
  assign fwd_hit_o  = 1'b0;
  assign fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer drain, alloc/commit/discard and load lookup
module tb_store_buffer;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alloc_valid_i;
  logic [31:0] alloc_addr_i, alloc_data_i;
  logic [1:0]  alloc_size_i;
  logic [1:0]  alloc_idx_o;
  logic        full_o, empty_o;
  logic        commit_valid_i;
  logic [1:0]  commit_idx_i;
  logic [3:0]  discard_i;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_req_addr_o, mem_req_data_o;
  logic [3:0]  mem_req_wstrb_o;
  logic        mem_resp_valid_i;
  logic [31:0] ld_addr_i;
  logic [1:0]  ld_size_i;
  logic        ld_conflict_o, fwd_hit_o;
  logic [31:0] fwd_data_o;

  always #5 clk_i = ~clk_i;

  store_buffer #(.STORE_BUFFER_SIZE(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_addr_i(alloc_addr_i), .alloc_data_i(alloc_data_i),
    .alloc_size_i(alloc_size_i), .alloc_idx_o(alloc_idx_o), .full_o(full_o), .empty_o(empty_o),
    .commit_valid_i(commit_valid_i), .commit_idx_i(commit_idx_i), .discard_i(discard_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_wstrb_o(mem_req_wstrb_o), .mem_resp_valid_i(mem_resp_valid_i),
    .ld_addr_i(ld_addr_i), .ld_size_i(ld_size_i), .ld_conflict_o(ld_conflict_o),
    .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
  } req_t;

  req_t exp_q[$];
  req_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  logic resp_pend = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  // Monitor: every accepted request is compared against the oldest expected write.
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i && mem_req_valid_o && mem_req_ready_i) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL drain_unexpected: got addr %h data %h, expected no request", mem_req_addr_o, mem_req_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("drain_addr", 72'(mem_req_addr_o), 72'(mon_e.addr));
          chk("drain_data", 72'(mem_req_data_o), 72'(mon_e.data));
          chk("drain_wstrb", 72'(mem_req_wstrb_o), 72'(mon_e.wstrb));
        end
      end
    end
  end

  // Memory responder: completion one cycle after each accepted request.
  initial begin
    mem_resp_valid_i = 1'b0;
    forever begin
      @(negedge clk_i);
      #1;
      mem_resp_valid_i = 1'b0;
      if (resp_pend) begin
        mem_resp_valid_i = 1'b1;
        resp_pend = 1'b0;
      end else if (!rst_i && mem_req_valid_o && mem_req_ready_i) begin
        resp_pend = 1'b1;
      end
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic do_alloc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    alloc_valid_i = 1'b1;
    alloc_addr_i  = a;
    alloc_data_i  = d;
    alloc_size_i  = s;
    cyc();
    alloc_valid_i = 1'b0;
  endtask

  task automatic do_commit(input logic [1:0] idx, input req_t e);
    commit_valid_i = 1'b1;
    commit_idx_i   = idx;
    exp_q.push_back(e);
    cyc();
    commit_valid_i = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!empty_o && n < 60) begin
      cyc();
      n++;
    end
    chk(name, 72'(empty_o), 72'(1));
  endtask

  task automatic lookup(input string name, input logic [31:0] a, input logic [1:0] s,
                        input logic c, input logic h, input logic [31:0] d);
    ld_addr_i = a;
    ld_size_i = s;
    #1;
    chk(name, {39'b0, ld_conflict_o, fwd_hit_o, fwd_data_o}, {39'b0, c, h, d});
  endtask

  initial begin
    rst_i = 1'b1;
    alloc_valid_i = 1'b0; alloc_addr_i = '0; alloc_data_i = '0; alloc_size_i = '0;
    commit_valid_i = 1'b0; commit_idx_i = '0; discard_i = '0;
    mem_req_ready_i = 1'b1; ld_addr_i = '0; ld_size_i = '0;
    cyc();
    cyc();
    chk("reset_full", 72'(full_o), 72'(0));
    chk("reset_empty", 72'(empty_o), 72'(1));
    chk("reset_alloc_idx", 72'(alloc_idx_o), 72'(0));
    chk("reset_req", {3'b0, mem_req_valid_o, mem_req_wstrb_o, mem_req_addr_o, mem_req_data_o}, 72'(0));
    chk("reset_ld", {39'b0, ld_conflict_o, fwd_hit_o, fwd_data_o}, 72'(0));
    rst_i = 1'b0;
    cyc();

    // Word store drains unchanged.
    do_alloc(32'h100, 32'hDEADBEEF, 2'b10);
    do_commit(2'd0, {32'h100, 32'hDEADBEEF, 4'hF});
    wait_empty("sw_drain_empty");
    chk("sw_head_advanced", 72'(alloc_idx_o), 72'(1));

    // Byte and half stores are lane-shifted.
    do_alloc(32'h203, 32'h000000AB, 2'b00);
    do_alloc(32'h202, 32'h00001234, 2'b01);
    do_commit(2'd1, {32'h200, 32'hAB000000, 4'b1000});
    do_commit(2'd2, {32'h200, 32'h12340000, 4'b1100});
    wait_empty("sb_sh_drain_empty");

    // Fill, overflow attempt, partial drain and wrap.
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(32'h300 + 32'(4 * i), 32'(i + 1), 2'b10);
    chk("fill_full", 72'(full_o), 72'(1));
    chk("fill_alloc_idx", 72'(alloc_idx_o), 72'(0));
    do_alloc(32'h3F0, 32'h99, 2'b10);
    chk("overflow_full", 72'(full_o), 72'(1));
    chk("overflow_alloc_idx", 72'(alloc_idx_o), 72'(0));
    do_commit(2'd0, {32'h300, 32'h1, 4'hF});
    begin
      int n = 0;
      while (full_o && n < 60) begin
        cyc();
        n++;
      end
    end
    chk("drain_one_not_full", 72'(full_o), 72'(0));
    chk("wrap_alloc_idx", 72'(alloc_idx_o), 72'(0));
    do_alloc(32'h310, 32'h5, 2'b10);
    chk("wrap_after_alloc_idx", 72'(alloc_idx_o), 72'(1));
    chk("wrap_full_again", 72'(full_o), 72'(1));
    discard_i = 4'b1111;
    cyc();
    discard_i = 4'b0000;
    chk("discard_all_empty", 72'(empty_o), 72'(1));
    chk("discard_all_tail", 72'(alloc_idx_o), 72'(1));

    // Discard with concurrent alloc, stalled request, commit racing discard.
    do_reset();
    do_alloc(32'h400, 32'hA0, 2'b10);
    do_alloc(32'h404, 32'hA1, 2'b10);
    do_alloc(32'h408, 32'hA2, 2'b10);
    mem_req_ready_i = 1'b0;
    do_commit(2'd0, {32'h400, 32'hA0, 4'hF});
    discard_i = 4'b0111;
    alloc_valid_i = 1'b1; alloc_addr_i = 32'h40C; alloc_data_i = 32'hEE; alloc_size_i = 2'b10;
    cyc();
    discard_i = 4'b0000;
    alloc_valid_i = 1'b0;
    chk("squash_tail", 72'(alloc_idx_o), 72'(1));
    chk("squash_not_empty", 72'(empty_o), 72'(0));
    chk("squash_not_full", 72'(full_o), 72'(0));
    for (int i = 0; i < 5; i++) begin
      chk("stall_stable", {3'b0, mem_req_valid_o, mem_req_wstrb_o, mem_req_addr_o, mem_req_data_o},
          {3'b0, 1'b1, 4'hF, 32'h400, 32'hA0});
      cyc();
    end
    do_alloc(32'h410, 32'hB1, 2'b10);
    commit_valid_i = 1'b1; commit_idx_i = 2'd1; discard_i = 4'b0010;
    exp_q.push_back({32'h410, 32'hB1, 4'hF});
    cyc();
    commit_valid_i = 1'b0; discard_i = 4'b0000;
    chk("commit_beats_discard_tail", 72'(alloc_idx_o), 72'(2));
    mem_req_ready_i = 1'b1;
    wait_empty("squash_drain_empty");

    // Load lookup against two word stores to the same address.
    do_reset();
    do_alloc(32'h40, 32'h11, 2'b10);
    do_alloc(32'h40, 32'h22, 2'b10);
`ifdef STORE_FORWARDING_EN
    lookup("lw_forward", 32'h40, 2'b10, 1'b0, 1'b1, 32'h22);
`else
    lookup("lw_conflict", 32'h40, 2'b10, 1'b1, 1'b0, 32'h0);
`endif
    lookup("lb_conflict", 32'h41, 2'b00, 1'b1, 1'b0, 32'h0);
    lookup("lw_nomatch", 32'h44, 2'b10, 1'b0, 1'b0, 32'h0);
    cyc();
    discard_i = 4'b0011;
    cyc();
    discard_i = 4'b0000;
    chk("ld_discard_empty", 72'(empty_o), 72'(1));
    lookup("ld_after_discard", 32'h40, 2'b10, 1'b0, 1'b0, 32'h0);

    cyc();
    cyc();
    chk("scoreboard_drained", 72'(exp_q.size()), 72'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
